// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory bus between fetch (IF) and data (DM).
// Optional bus watchdog: define BUS_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RSP_I,
    RSP_D
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          done_i, done_d;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    done_i     = 1'b0;
    done_d     = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_be     = 4'h0;
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;
`ifdef BUS_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef BUS_TIMEOUT_EN
        tmo_d = '0;
`endif
        // Data wins unless fetch has been starved for a full streak.
        if (dm_req && (!if_req || streak_q < SMAX)) begin
          state_d  = GNT_D;
          streak_d = !if_req ? '0 :
                     (streak_q == SMAX) ? SMAX : streak_q + SW'(1);
        end else if (if_req) begin
          state_d  = GNT_I;
          streak_d = '0;
        end
      end
      GNT_I: begin
        bus_req  = 1'b1;
        bus_be   = 4'hF;
        bus_addr = if_addr;
        if (bus_ack) begin
          if_rdata_d = bus_rdata;
          state_d    = RSP_I;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TLAST) begin
          if_rdata_d = 32'h0000_0013;
          err_d      = 1'b1;
          state_d    = RSP_I;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      GNT_D: begin
        bus_req   = 1'b1;
        bus_we    = dm_we;
        bus_be    = dm_be;
        bus_addr  = dm_addr;
        bus_wdata = dm_wdata;
        if (bus_ack) begin
          if (!dm_we) dm_rdata_d = bus_rdata;
          state_d = RSP_D;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TLAST) begin
          dm_rdata_d = 32'h0;
          err_d      = 1'b1;
          state_d    = RSP_D;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      RSP_I: begin
        done_i  = 1'b1;
        state_d = IDLE;
      end
      RSP_D: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_valid = ~if_req | done_i;
  assign dm_valid = ~dm_req | done_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, bus-beat scoreboard, corner cases.
// Build with BUS_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_port_arbiter;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  mem_port_arbiter #(
    .MAX_D_STREAK  (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_be   (bus_be),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  vec_t  vecs[5];
  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] a);
    beat_t b;
    b.addr = a; b.we = 1'b0; b.be = 4'hF; b.wdata = 32'h0;
    sb.push_back(b);
  endtask

  task automatic push_dm(input logic [31:0] a, input logic w,
                         input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.we = w; b.be = be; b.wdata = wd;
    sb.push_back(b);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!bus_req && n < 20) begin
      step();
      n++;
    end
    if (!bus_req) chk("grant_timeout", 32'(bus_req), 32'h1);
  endtask

  task automatic check_grant();
    beat_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk("bus_addr", bus_addr, e.addr);
      chk("bus_we", 32'(bus_we), 32'(e.we));
      chk("bus_be", 32'(bus_be), 32'(e.be));
      chk("bus_wdata", bus_wdata, e.wdata);
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_be = v.be;
      dm_addr = v.addr; dm_wdata = v.wdata;
      push_dm(v.addr, v.we, v.be, v.wdata);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      push_if(v.addr);
    end
    step();
    wait_grant();
    check_grant();
    for (int k = 0; k < v.dly; k++) begin
      chk("wait_valid", 32'(v.dm ? dm_valid : if_valid), 32'h0);
      chk("wait_be", 32'(bus_be), v.dm ? 32'(v.be) : 32'hF);
      step();
    end
    bus_ack = 1'b1; bus_rdata = v.rdata;
    step();
    bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rsp_valid", 32'(v.dm ? dm_valid : if_valid), 32'h1);
    chk("rsp_rdata", v.dm ? dm_rdata : if_rdata, v.exp_rdata);
    chk("rsp_busreq", 32'(bus_req), 32'h0);
    dm_req = 1'b0; if_req = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{0, 0, 4'hF, 32'h100, 32'h0, 32'h0050_0093, 0, 32'h0050_0093};
    vecs[1] = '{1, 0, 4'hF, 32'h2000, 32'h0, 32'h1122_3344, 2, 32'h1122_3344};
    vecs[2] = '{1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 5,
                32'h1122_3344};
    vecs[3] = '{0, 0, 4'hF, 32'h104, 32'h0, 32'h00A0_0113, 1, 32'h00A0_0113};
    vecs[4] = '{1, 0, 4'b1100, 32'h2004, 32'h0, 32'h5566_7788, 0,
                32'h5566_7788};

    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    bus_ack = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // first IF: bus_req one cycle after request, valid one later
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("t1_idle_valid", 32'(if_valid), 32'h0);
    if_req = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // simultaneous requests: data first, fetch after a bubble
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF;
    dm_addr = 32'h2000; dm_wdata = 32'h0;
    push_dm(32'h2000, 1'b0, 4'hF, 32'h0);
    push_if(32'h300);
    step();
    chk("pri_busreq", 32'(bus_req), 32'h1);
    check_grant();
    chk("pri_if_valid", 32'(if_valid), 32'h0);
    chk("pri_dm_valid", 32'(dm_valid), 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h0000_CAFE;
    step();
    bus_ack = 1'b0;
    #1;
    chk("pri_rspd_dm", 32'(dm_valid), 32'h1);
    chk("pri_rspd_if", 32'(if_valid), 32'h0);
    dm_req = 1'b0;
    step();
    chk("pri_bubble", 32'(bus_req), 32'h0);
    step();
    check_grant();
    bus_ack = 1'b1; bus_rdata = 32'h0000_0513;
    step();
    bus_ack = 1'b0;
    #1;
    chk("pri_rspi_valid", 32'(if_valid), 32'h1);
    chk("pri_if_rdata", if_rdata, 32'h0000_0513);
    chk("pri_dm_rdata", dm_rdata, 32'h0000_CAFE);
    if_req = 1'b0;
    step();

    // ack while idle is ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    step();
    chk("stray_busreq", 32'(bus_req), 32'h0);
    chk("stray_if_rdata", if_rdata, 32'h0000_0513);
    chk("stray_dm_rdata", dm_rdata, 32'h0000_CAFE);
    bus_ack = 1'b0;

    // streak: four data grants, then fetch is forced, then data again
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h4000;
    if_req = 1'b1; if_addr = 32'h200;
    for (int j = 0; j < 6; j++) begin
      if (j == 4) push_if(32'h200);
      else push_dm(32'h4000, 1'b0, 4'hF, 32'h0);
    end
    for (int j = 0; j < 6; j++) begin
      wait_grant();
      check_grant();
      bus_ack = 1'b1; bus_rdata = 32'(j);
      step();
      bus_ack = 1'b0;
      #1;
      chk("streak_done",
          32'({dm_valid, if_valid}),
          (j == 4) ? 32'h1 : 32'h2);
      step();
    end
    dm_req = 1'b0; if_req = 1'b0;
    step();
    chk("streak_if_rdata", if_rdata, 32'h4);

    // requester drops req mid-grant: transaction still completes
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF;
    dm_addr = 32'h5000; dm_wdata = 32'h1;
    step();
    dm_req = 1'b0;
    #1;
    chk("drop_busreq", 32'(bus_req), 32'h1);
    chk("drop_valid", 32'(dm_valid), 32'h1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    #1;
    chk("drop_rsp_busreq", 32'(bus_req), 32'h0);
    step();
    step();
    chk("drop_idle_busreq", 32'(bus_req), 32'h0);

    // async reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("arst_pre_busreq", 32'(bus_req), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busreq", 32'(bus_req), 32'h0);
    chk("arst_busaddr", bus_addr, 32'h0);
    chk("arst_if_rdata", if_rdata, 32'h0);
    chk("arst_dm_rdata", dm_rdata, 32'h0);
    chk("arst_if_valid", 32'(if_valid), 32'h0);
    if_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("arst_idle_busreq", 32'(bus_req), 32'h0);
    chk("err_clear", 32'(bus_err), 32'h0);

`ifdef BUS_TIMEOUT_EN
    if_req = 1'b1; if_addr = 32'h700;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("tmo_gnt_busreq", 32'(bus_req), 32'h1);
      step();
    end
    chk("tmo_rsp_busreq", 32'(bus_req), 32'h0);
    chk("tmo_if_valid", 32'(if_valid), 32'h1);
    chk("tmo_if_rdata", if_rdata, 32'h0000_0013);
    chk("tmo_err", 32'(bus_err), 32'h1);
    if_req = 1'b0;
    step();
    step();
    chk("tmo_err_sticky", 32'(bus_err), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("tmo_err_rst", 32'(bus_err), 32'h0);
    reset_n = 1'b1;
    step();
`endif

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one variable-latency memory bus between instruction fetch (IF) and data memory (DM) requesters.
- Generates per-requester valid flags that feed the hazard unit's memValid1 (IF) and memValid2 (DM) stall inputs.
- Data has priority. A streak counter guarantees fetch forward progress.
- Sits between the pipeline's fetch/memory stages and the single external memory bus.

Parameters:
- MAX_D_STREAK, 4: consecutive DM grants allowed while IF is pending before IF is forced.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction, registered
- if_valid  out  1  to hazard memValid1; 1 = fetch not stalling
- dm_req  in  1  data request; held with its qualifiers until dm_valid
- dm_we  in  1  1 = write
- dm_be  in  4  byte enables
- dm_addr  in  32  data address
- dm_wdata  in  32  write data
- dm_rdata  out  32  load data, registered
- dm_valid  out  1  to hazard memValid2; 1 = data access not stalling
- bus_req  out  1  bus transaction active
- bus_we  out  1  write strobe (0 for IF)
- bus_be  out  4  byte enables (4'hF for IF)
- bus_addr  out  32  bus address
- bus_wdata  out  32  write data (0 for IF)
- bus_ack  in  1  completion; sampled only while bus_req=1
- bus_rdata  in  32  read data, valid with bus_ack
- bus_err  out  1  sticky timeout flag (0 when feature is off)

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D, RSP_I, RSP_D.
- Reset (async, reset_n=0):
  - state=IDLE; streak=0; if_rdata=0; dm_rdata=0; bus_err=0.
  - All bus_* outputs are 0. A transaction in progress is abandoned immediately, with bus_req dropping asynchronously.
- IDLE:
  - dm_req=1 and (if_req=0 or streak<MAX_D_STREAK): go to GNT_D, streak+=1 if if_req=1, else streak=0.
  - Otherwise if if_req=1: go to GNT_I, streak=0.
  - Neither request: stay in IDLE.
- GNT_x:
  - bus_req=1. Other bus_* outputs are driven combinationally from the granted requester's held inputs.
  - On bus_ack=1: capture bus_rdata into x_rdata (DM captures on reads only; dm_rdata holds on writes), then go to RSP_x.
  - Ack may arrive in the first GNT cycle.
- RSP_x: single cycle, bus_req=0, done_x=1, next state IDLE. No new grant is issued in RSP, so the requester can update its request.
- Valid flags: if_valid = ~if_req | done_I; dm_valid = ~dm_req | done_D. done_x is 1 only in RSP_x.
- Minimum latency: request seen in IDLE at cycle n, bus_req at n+1 with ack at n+1, valid at n+2, so 3 cycles per access.
- Back-to-back: after RSP the next grant comes from IDLE, giving one bus-idle bubble per access.
- Requester drops its req during GNT: the transaction still completes; done is produced but valid is already 1 via ~req. Dropping req is a protocol violation but must not hang the FSM.
- bus_ack while not in GNT is ignored.
- Streak counter: saturates at MAX_D_STREAK; width is clog2(MAX_D_STREAK+1).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Enabled:
  - A counter runs in GNT_x.
  - When it reaches TIMEOUT_CYCLES with no ack: go to RSP_x and load x_rdata with 32'h0000_0013 (NOP) for IF, or 32'h0 for DM; set bus_err=1 (sticky until reset).
  - The counter clears on entering GNT.
- Disabled: no counter; GNT waits indefinitely; bus_err tied to 0.

Test Plan:
- Reset release, if_req=1, if_addr=0x100, ack in first GNT cycle with rdata=0x00500093 -> bus_req high cycle 1, if_valid=1 and if_rdata=0x00500093 cycle 2.
- if_req and dm_req (dm_we=0, addr=0x2000) raised same cycle -> DM granted first with bus_addr=0x2000 and if_valid=0; IF granted after RSP_D.
- dm_req held continuously, if_req=1, MAX_D_STREAK=4 -> exactly 4 DM grants then one IF grant; streak returns to 0.
- DM write be=4'b0011, wdata=0xDEADBEEF, ack after 5 wait cycles -> bus_we=1, bus_be=0011 throughout GNT_D; dm_valid=0 until RSP_D; dm_rdata unchanged.
- reset_n pulled low in GNT_I mid-transaction -> bus_req=0 immediately, state IDLE, if_rdata=0.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack on IF -> RSP_I after 8 GNT cycles, if_rdata=0x00000013, bus_err=1 held until reset.
